text_overlay_engine: RTL
========================

// Module: text_overlay_engine
// PURPOSE
// - Parametrised VGA text overlay. Replaces per-character hard-wired instances with NUM_FIELDS
//   runtime-configurable text fields (position, length, visibility, invert) plus a writable char buffer.
// - Sits between vga_sync (x, y, video_on, hsync, vsync) and the DAC. Drives ascii_rom externally.
// - Pipelined to absorb the ROM's 1-cycle read latency; syncs are delayed to stay pixel-aligned.
// PARAMETERS
// - NUM_FIELDS  8        number of independent text fields (1..16)
// - FIELD_LEN   8        max characters per field (1..16)
// - FG_COLOR    12'hFFF  glyph pixel colour
// - BG_COLOR    12'h008  background colour while video_on
// PORTS
// - clk          in   1    pixel clock (single clock domain)
// - reset        in   1    synchronous, active-high
// - cfg_en       in   1    strobe: load config of field cfg_field
// - cfg_field    in   4    field index; values >= NUM_FIELDS are ignored
// - cfg_x        in   10   field origin x (left pixel)
// - cfg_y        in   10   field origin y (top pixel)
// - cfg_len      in   5    characters shown; values > FIELD_LEN clamp to FIELD_LEN; 0 = nothing shown
// - cfg_vis      in   1    field visible
// - cfg_inv      in   1    invert: FG/BG swapped inside the field's cells
// - wr_en        in   1    strobe: write wr_char to buffer[wr_field][wr_idx]
// - wr_field     in   4    field index; >= NUM_FIELDS ignored
// - wr_idx       in   4    char index; >= FIELD_LEN ignored
// - wr_char      in   7    ASCII code
// - video_on     in   1    from vga_sync
// - x, y         in   10   pixel coordinate from vga_sync
// - hsync_in     in   1    from vga_sync
// - vsync_in     in   1    from vga_sync
// - rom_addr     out  11   {ascii[6:0], glyph_row[3:0]} to ascii_rom
// - rom_data     in   8    glyph row from ascii_rom; valid 1 cycle after rom_addr
// - hsync        out  1    hsync_in delayed 3 cycles
// - vsync        out  1    vsync_in delayed 3 cycles
// - rgb          out  12   pixel colour, aligned with hsync/vsync
// BEHAVIOUR
// - Reset: all buffer chars = 7'h20 (space); all fields cfg_vis=0, cfg_inv=0, x=y=len=0;
//   rom_addr=0; rgb=0; hsync=vsync=0; all pipeline valid/hit flags cleared. Reset mid-frame is
//   honoured on the next edge; the first 3 output cycles after release are rgb=0.
// - Hit test (stage 0, cycle N): field f hits iff vis && y-fy in [0,15] && x-fx in [0, 8*len-1]
//   (unsigned 10-bit subtraction; x < fx or y < fy never hits). col = (x-fx)>>3, row = (y-fy)[3:0],
//   bit = (x-fx)[2:0]. Several fields hit -> lowest index wins. No hit -> ascii 7'h20.
// - Stage 0 registers rom_addr={char,row}, bit, hit, inv, video_on, syncs (valid at N+1).
// - Stage 1: rom_data valid at N+2; pixel = rom_data[7-bit]; stage-1 regs carry bit/hit/inv/video_on.
// - Stage 2: rgb registered -> valid at N+3:
//   !video_on -> 0; else glyph = hit & pixel; rgb = (glyph ^ (hit & inv)) ? FG_COLOR : BG_COLOR.
//   Inverted field: cell background FG_COLOR, glyph BG_COLOR. hsync/vsync: 3-stage shift, same latency.
// - Writes/config take effect on the edge where the strobe is high; a render read of the same
//   entry in that cycle sees the OLD value. wr_en and cfg_en in the same cycle are independent.
// - Clipping: cells past x=639 / y=479 are masked by video_on only; no wrap-around of x or y.
// STRUCTURE
// - text_overlay_defs.vh: CHAR_W=8, CHAR_H=16, ASCII_SPACE=7'h20, PIPE_LAT=3, default colours.
// - Sub-module text_field_hit (one per field, generate loop): config regs + hit/col/row/bit calc.
// - Top: char buffer (reg array NUM_FIELDS*FIELD_LEN x 7), priority encoder, 3-stage pipeline.
// - ascii_rom stays outside the block; a bench model with 1-cycle latency is used for verification.
// TESTING
// - After reset, field 0 cfg (80,80,len=5,vis), no writes -> rgb = BG_COLOR wherever video_on, 0 elsewhere.
// - Write "SPEED" to field 0 -> pixel (80+c*8+b, 80+r) rgb matches ROM bit of char c, row r; hsync/vsync delay = 3.
// - Fields 0 and 1 both cover (120,80), field 1 'A', field 0 'B' -> field 0 ('B') glyph shown.
// - cfg_inv=1 on field 2 'space' -> whole 8*len x 16 box = FG_COLOR; cfg_len=20 clamps to FIELD_LEN.
// - wr_idx=FIELD_LEN, cfg_field=NUM_FIELDS, cfg_len=0 -> no buffer/config change, field renders nothing.
// - Assert reset mid-line while fields visible -> next 3 cycles rgb=0, then buffer is all spaces, fields hidden.

Source files
------------

// File: rtl/text_overlay_engine_pkg.sv
// Shared constants and types for the text overlay engine.
//   CHAR_W/CHAR_H : glyph cell size in pixels
//   ASCII_SPACE   : code rendered where no field covers the pixel
//   PIPE_LAT      : cycles from (x, y, syncs) in to rgb/hsync/vsync out
//   DEF_FG/DEF_BG : default glyph / background colours
package text_overlay_engine_pkg;

   localparam int          CHAR_W      = 8;
   localparam int          CHAR_H      = 16;
   localparam logic [6:0]  ASCII_SPACE = 7'h20;
   localparam int          PIPE_LAT    = 3;
   localparam logic [11:0] DEF_FG      = 12'hFFF;
   localparam logic [11:0] DEF_BG      = 12'h008;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [4:0] len;
      logic       vis;
      logic       inv;
   } field_cfg_t;

   // per-pixel attributes carried alongside the ROM lookup
   typedef struct packed {
      logic [2:0] pix_bit;
      logic       hit;
      logic       inv;
      logic       von;
   } pipe_t;

   function automatic logic [4:0] clamp_len(input logic [4:0] len, input int max_len);
      if (int'(len) > max_len) return 5'(max_len);
      return len;
   endfunction

endpackage

// File: rtl/text_overlay_engine_field_hit.sv
// One text field: holds its configuration registers and decides whether
// the current pixel lies inside one of its character cells.
//   clk, reset                   : pixel clock, synchronous active-high reset
//   cfg_en, cfg_field, cfg_*     : config load strobe; loaded when cfg_field == FIELD_IDX
//   x, y                         : current pixel coordinate
//   hit                          : pixel inside a visible cell of this field
//   inv                          : field's invert flag
//   col, row, pix_bit            : cell index, glyph row, glyph column within the cell
module text_overlay_engine_field_hit
   import text_overlay_engine_pkg::*;
#(
   parameter int FIELD_IDX = 0,
   parameter int FIELD_LEN = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_en,
   input  logic [3:0] cfg_field,
   input  logic [9:0] cfg_x,
   input  logic [9:0] cfg_y,
   input  logic [4:0] cfg_len,
   input  logic       cfg_vis,
   input  logic       cfg_inv,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic       hit,
   output logic       inv,
   output logic [3:0] col,
   output logic [3:0] row,
   output logic [2:0] pix_bit
);

   field_cfg_t cfg_q, cfg_d;
   logic [9:0] dx, dy;

   always_comb begin
      cfg_d = cfg_q;
      if (cfg_en && (cfg_field == 4'(FIELD_IDX))) begin
         cfg_d.x   = cfg_x;
         cfg_d.y   = cfg_y;
         cfg_d.len = clamp_len(cfg_len, FIELD_LEN);
         cfg_d.vis = cfg_vis;
         cfg_d.inv = cfg_inv;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cfg_q <= '0;
      else       cfg_q <= cfg_d;
   end

   // The explicit >= compares stop a wrapped subtraction (x < origin) from
   // landing back inside the box.
   always_comb begin
      dx      = x - cfg_q.x;
      dy      = y - cfg_q.y;
      hit     = cfg_q.vis && (x >= cfg_q.x) && (y >= cfg_q.y) &&
                (dy < 10'(CHAR_H)) && (dx < {2'b00, cfg_q.len, 3'b000});
      inv     = cfg_q.inv;
      col     = dx[6:3];
      row     = dy[3:0];
      pix_bit = dx[2:0];
   end

endmodule

// File: rtl/text_overlay_engine.sv
// VGA text overlay with NUM_FIELDS runtime-configurable text fields.
// Sits between the sync generator and the DAC; the glyph ROM is external
// with one cycle of read latency. Output is three cycles behind x/y.
//   clk, reset                     : pixel clock, synchronous active-high reset
//   cfg_en, cfg_field, cfg_x/y/len, cfg_vis, cfg_inv : field configuration
//   wr_en, wr_field, wr_idx, wr_char                  : character buffer write
//   video_on, x, y, hsync_in, vsync_in                : from the sync generator
//   rom_addr / rom_data            : {ascii, glyph_row} out, glyph row back next cycle
//   hsync, vsync, rgb              : pixel-aligned outputs to the DAC
module text_overlay_engine
   import text_overlay_engine_pkg::*;
#(
   parameter int          NUM_FIELDS = 8,
   parameter int          FIELD_LEN  = 8,
   parameter logic [11:0] FG_COLOR   = DEF_FG,
   parameter logic [11:0] BG_COLOR   = DEF_BG
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_en,
   input  logic [3:0]  cfg_field,
   input  logic [9:0]  cfg_x,
   input  logic [9:0]  cfg_y,
   input  logic [4:0]  cfg_len,
   input  logic        cfg_vis,
   input  logic        cfg_inv,
   input  logic        wr_en,
   input  logic [3:0]  wr_field,
   input  logic [3:0]  wr_idx,
   input  logic [6:0]  wr_char,
   input  logic        video_on,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb
);

   localparam int DEPTH = NUM_FIELDS * FIELD_LEN;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SLOTS = 1 << AW;

   // character buffer, field-major
   logic [6:0]    buf_q [SLOTS];
   logic [6:0]    buf_d [SLOTS];
   logic          wr_ok;
   logic [AW-1:0] wr_addr;

   always_comb begin
      wr_ok   = wr_en && ({1'b0, wr_field} < 5'(NUM_FIELDS)) && ({1'b0, wr_idx} < 5'(FIELD_LEN));
      wr_addr = AW'(int'(wr_field) * FIELD_LEN + int'(wr_idx));
      buf_d   = buf_q;
      if (wr_ok) buf_d[wr_addr] = wr_char;
   end

   // per-field hit test
   logic [NUM_FIELDS-1:0] hit_v, inv_v;
   logic [3:0]            col_v [NUM_FIELDS];
   logic [3:0]            row_v [NUM_FIELDS];
   logic [2:0]            bit_v [NUM_FIELDS];

   for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
      text_overlay_engine_field_hit #(
         .FIELD_IDX (g),
         .FIELD_LEN (FIELD_LEN)
      ) u_hit (
         .clk       (clk),
         .reset     (reset),
         .cfg_en    (cfg_en),
         .cfg_field (cfg_field),
         .cfg_x     (cfg_x),
         .cfg_y     (cfg_y),
         .cfg_len   (cfg_len),
         .cfg_vis   (cfg_vis),
         .cfg_inv   (cfg_inv),
         .x         (x),
         .y         (y),
         .hit       (hit_v[g]),
         .inv       (inv_v[g]),
         .col       (col_v[g]),
         .row       (row_v[g]),
         .pix_bit   (bit_v[g])
      );
   end

   // priority select: scan downward so the lowest hitting index is kept
   logic          sel_hit, sel_inv;
   int            sel_field;
   logic [3:0]    sel_col, sel_row;
   logic [2:0]    sel_bit;
   logic [AW-1:0] rd_addr;
   logic [6:0]    ascii;

   always_comb begin
      sel_hit   = 1'b0;
      sel_inv   = 1'b0;
      sel_field = 0;
      sel_col   = '0;
      sel_row   = '0;
      sel_bit   = '0;
      for (int f = NUM_FIELDS - 1; f >= 0; f--) begin
         if (hit_v[f]) begin
            sel_hit   = 1'b1;
            sel_inv   = inv_v[f];
            sel_field = f;
            sel_col   = col_v[f];
            sel_row   = row_v[f];
            sel_bit   = bit_v[f];
         end
      end
      rd_addr = AW'(sel_field * FIELD_LEN + int'(sel_col));
      ascii   = sel_hit ? buf_q[rd_addr] : ASCII_SPACE;
   end

   // three-stage pixel pipeline
   logic [10:0]         rom_addr_q, rom_addr_d;
   pipe_t               s0_q, s0_d, s1_q, s1_d;
   logic [11:0]         rgb_q, rgb_d;
   logic [PIPE_LAT-1:0] hs_q, hs_d, vs_q, vs_d;
   logic                pixel, glyph;

   always_comb begin
      rom_addr_d = {ascii, sel_row};
      s0_d       = '{pix_bit: sel_bit, hit: sel_hit, inv: sel_inv, von: video_on};
      s1_d       = s0_q;
      hs_d       = {hs_q[PIPE_LAT-2:0], hsync_in};
      vs_d       = {vs_q[PIPE_LAT-2:0], vsync_in};
      // rom_data now answers the address registered alongside s0, i.e. s1's pixel
      pixel      = rom_data[3'd7 - s1_q.pix_bit];
      glyph      = s1_q.hit & pixel;
      if (!s1_q.von)                        rgb_d = '0;
      else if (glyph ^ (s1_q.hit & s1_q.inv)) rgb_d = FG_COLOR;
      else                                  rgb_d = BG_COLOR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SLOTS; i++) buf_q[i] <= ASCII_SPACE;
         rom_addr_q <= '0;
         s0_q       <= '0;
         s1_q       <= '0;
         rgb_q      <= '0;
         hs_q       <= '0;
         vs_q       <= '0;
      end else begin
         buf_q      <= buf_d;
         rom_addr_q <= rom_addr_d;
         s0_q       <= s0_d;
         s1_q       <= s1_d;
         rgb_q      <= rgb_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign rgb      = rgb_q;
   assign hsync    = hs_q[PIPE_LAT-1];
   assign vsync    = vs_q[PIPE_LAT-1];

endmodule
